// File: rtl/count_sampler_pkg.sv
// Shared widths and helpers for the count sampler.
package count_sampler_pkg;

  localparam int GAP_W  = 16;
  localparam int DROP_W = 8;

  typedef logic [GAP_W-1:0]  gap_t;
  typedef logic [DROP_W-1:0] drop_t;

  // Increment that sticks at all-ones instead of rolling over.
  function automatic gap_t gap_inc(input gap_t g);
    return (g == '1) ? g : g + gap_t'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO. The head entry is visible on rdata
// whenever empty is low; pop consumes it. Pointers carry one extra wrap bit
// so full and empty can be told apart without an occupancy counter.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are meaningless until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/count_sampler.sv
// Snapshots a counter on capture requests, tagging each sample with a
// wrap-since-last-sample flag and the cycle gap, and queues the samples.
// Output handshake: an entry transfers on any rising edge where out_valid
// and out_ready are both high; while out_valid is high and out_ready is low
// the head fields hold steady, and out_valid never depends on out_ready.
module count_sampler
  import count_sampler_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  count,
  input  logic              capture,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_count,
  output logic              out_wrap,
  output logic [GAP_W-1:0]  out_gap,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overrun
);

  typedef logic [WIDTH-1:0] cnt_t;

  typedef struct packed {
    cnt_t count;
    logic wrap;
    gap_t gap;
  } sample_t;

  localparam cnt_t CNT_ONES = '1;

  cnt_t    prev_q;
  logic    wrap_acc;
  gap_t    gap_cnt;
  logic    wrap_now;
  logic    pop;
  logic    push_ok;
  logic    drop;
  logic    fifo_full;
  logic    fifo_empty;
  sample_t entry;
  sample_t head;

  // A jump between the two extremes is treated as a wrap in either direction.
  assign wrap_now = ((prev_q == CNT_ONES) && (count == '0)) ||
                    ((prev_q == '0) && (count == CNT_ONES));

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push_ok   = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;

  assign entry.count = count;
  assign entry.wrap  = wrap_acc | wrap_now;
  assign entry.gap   = gap_inc(gap_cnt);

  // Zero the visible fields while empty so stale storage never leaks out.
  assign out_count = fifo_empty ? '0 : head.count;
  assign out_wrap  = fifo_empty ? 1'b0 : head.wrap;
  assign out_gap   = fifo_empty ? '0 : head.gap;

  // Wrap and gap tracking; a dropped capture leaves both accumulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      wrap_acc <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      prev_q <= count;
      if (push_ok) begin
        wrap_acc <= wrap_now;
        gap_cnt  <= gap_t'(1);
      end else begin
        wrap_acc <= wrap_acc | wrap_now;
        gap_cnt  <= gap_inc(gap_cnt);
      end
    end
  end

  // Drop accounting; a drop coinciding with clr still registers as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overrun  <= 1'b0;
    end else if (clr) begin
      drop_cnt <= drop_t'(drop);
      overrun  <= drop;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + drop_t'(1);
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .wdata (entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (head)
  );

endmodule

// File: tb/tb_count_sampler.sv
// Directed bench for count_sampler with hand-computed expectations.
module tb_count_sampler;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int EW    = WIDTH + 1 + 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] count;
  logic             capture;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic             out_wrap;
  logic [15:0]      out_gap;
  logic [7:0]       drop_cnt;
  logic             overrun;

  int n_chk;
  int n_bad;

  // Expected FIFO contents as {count, wrap, gap}, all hand-computed.
  logic [EW-1:0] exp_q[$];

  count_sampler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (count),
    .capture   (capture),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_wrap  (out_wrap),
    .out_gap   (out_gap),
    .drop_cnt  (drop_cnt),
    .overrun   (overrun)
  );

  // Clock and cycle guard
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are observed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [EW-1:0] e);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_count"}, 32'(out_count), 32'(e[EW-1 -: WIDTH]));
    chk({tag, "_wrap"},  32'(out_wrap),  32'(e[16]));
    chk({tag, "_gap"},   32'(out_gap),   32'(e[15:0]));
  endtask

  initial begin
    logic [EW-1:0] e;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    count = '0;
    capture = 1'b0;
    clr = 1'b0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_wrap",  32'(out_wrap),  32'd0);
    chk("rst_gap",   32'(out_gap),   32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    chk("rst_ovr",   32'(overrun),   32'd0);

    // Single capture after 20 idle cycles: gap counts 21 edges from release
    rst_n = 1'b1;
    count = 8'h2A;
    repeat (20) tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk_head("single", {8'h2A, 1'b0, 16'd21});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop", 32'(out_valid), 32'd0);

    // Wrap FF->00 between samples; gap_cnt reaches 5 before the capture
    count = 8'hFE; tick();
    count = 8'hFF; tick();
    count = 8'h00; tick();
    count = 8'h01; capture = 1'b1; tick();
    capture = 1'b0;
    chk_head("wrap", {8'h01, 1'b1, 16'd6});
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    count = 8'h05; capture = 1'b1; tick();
    capture = 1'b0;
    chk_head("nowrap", {8'h05, 1'b0, 16'd3});
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    chk("nowrap_pop", 32'(out_valid), 32'd0);

    // Overrun: six back-to-back captures into four slots
    exp_q.push_back({8'h10, 1'b0, 16'd3});
    exp_q.push_back({8'h11, 1'b0, 16'd2});
    exp_q.push_back({8'h12, 1'b0, 16'd2});
    exp_q.push_back({8'h13, 1'b0, 16'd2});
    capture = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count = 8'(8'h10 + i);
      tick();
    end
    capture = 1'b0;
    chk("ovr_drop", 32'(drop_cnt), 32'd2);
    chk("ovr_flag", 32'(overrun),  32'd1);
    chk_head("ovr_head", exp_q[0]);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_flag", 32'(overrun),  32'd0);
    chk_head("clr_head", exp_q[0]);

    // Full FIFO with pop and capture together: no drop, occupancy kept
    out_ready = 1'b1; capture = 1'b1; count = 8'h20;
    tick();
    out_ready = 1'b0; capture = 1'b0;
    e = exp_q.pop_front();
    exp_q.push_back({8'h20, 1'b0, 16'd5});
    chk("fullpp_drop", 32'(drop_cnt), 32'd0);
    chk_head("fullpp_head", exp_q[0]);
    // Still full: a lone capture must drop
    capture = 1'b1; count = 8'h21; tick();
    capture = 1'b0;
    chk("full_drop", 32'(drop_cnt), 32'd1);
    chk("full_ovr",  32'(overrun),  32'd1);

    // Backpressure: head must hold for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("hold", exp_q[0]);
    end

    // Drain in order, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      chk_head("drain", e);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream with three entries queued and a drop on record
    capture = 1'b1;
    for (int i = 0; i < 3; i++) begin
      count = 8'(8'h30 + i);
      tick();
    end
    capture = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_drop",  32'(drop_cnt),  32'd0);
    chk("mid_rst_ovr",   32'(overrun),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    count = 8'h40;
    repeat (4) tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    capture = 1'b1; tick();
    capture = 1'b0;
    chk_head("post_rst", {8'h40, 1'b0, 16'd5});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
